multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle variant of the core.
- Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and memory ports.
- Generates all datapath enables and mux selects from the opcode/funct3/rd fields delivered by the decoder.
- Handles memory handshakes with timeout, flags illegal opcodes, and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 28 ++
 rtl/multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle control FSM and the
// instruction/data memory ports.
interface multicycle_ctrl_if;
   logic       imem_req;
   logic       imem_ack;
   logic       dmem_req;
   logic       dmem_we;
   logic [2:0] dmem_size;
   logic       dmem_ack;

   modport master (
      output imem_req,
      input  imem_ack,
      output dmem_req,
      output dmem_we,
      output dmem_size,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      output imem_ack,
      input  dmem_req,
      input  dmem_we,
      input  dmem_size,
      output dmem_ack
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle core: fetch/decode/exec/mem/writeback
// sequencing, datapath strobes, memory handshakes with timeout, retire count.
module multicycle_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   multicycle_ctrl_if.master        mem,
   input  logic [6:0]               operation,
   input  logic [2:0]               funct3,
   input  logic [4:0]               rd,
   input  logic                     br_taken,
   input  logic                     instret_we,
   input  logic [31:0]              instret_wdata,
   output logic                     ir_we,
   output logic                     alu_src_a,
   output logic                     alu_src_b,
   output logic                     rf_we,
   output logic [1:0]               wb_sel,
   output logic                     pc_we,
   output logic [1:0]               pc_sel,
   output logic                     retire,
   output logic [31:0]              instret,
   output logic                     illegal,
   output logic                     bus_err
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [3:0] {
      C_LOAD,
      C_STORE,
      C_OPIMM,
      C_OP,
      C_BRANCH,
      C_JAL,
      C_JALR,
      C_LUI,
      C_AUIPC,
      C_ILL
   } cls_t;

   function automatic cls_t classify(input logic [6:0] op);
      cls_t c;
      case (op)
         7'b0000011: c = C_LOAD;
         7'b0100011: c = C_STORE;
         7'b0010011: c = C_OPIMM;
         7'b0110011: c = C_OP;
         7'b1100011: c = C_BRANCH;
         7'b1101111: c = C_JAL;
         7'b1100111: c = C_JALR;
         7'b0110111: c = C_LUI;
         7'b0010111: c = C_AUIPC;
         default:    c = C_ILL;
      endcase
      return c;
   endfunction

   state_t           state, state_d;
   cls_t             cls_q, dec_cls;
   logic [4:0]       rd_q;
   logic [2:0]       f3_q;
   logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
   logic             run;
   logic [31:0]      instret_q;
   logic             illegal_q, bus_err_q;
   logic             set_ill, set_bus;
   logic             imem_req_c, dmem_req_c, dmem_we_c;
   logic [2:0]       dmem_size_c;

   assign dec_cls       = classify(operation);
   assign cnt_inc       = cnt + 1'b1;
   assign mem.imem_req  = imem_req_c;
   assign mem.dmem_req  = dmem_req_c;
   assign mem.dmem_we   = dmem_we_c;
   assign mem.dmem_size = dmem_size_c;
   assign instret       = instret_q;
   assign illegal       = illegal_q;
   assign bus_err       = bus_err_q;

   always_comb begin
      state_d     = state;
      cnt_d       = cnt;
      set_ill     = 1'b0;
      set_bus     = 1'b0;
      imem_req_c  = 1'b0;
      ir_we       = 1'b0;
      dmem_req_c  = 1'b0;
      dmem_we_c   = 1'b0;
      dmem_size_c = 3'b000;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 2'b00;
      pc_we       = 1'b0;
      pc_sel      = 2'b00;
      retire      = 1'b0;

      unique case (state)
         S_FETCH: begin
            // run keeps the request low until the first edge after reset release
            if (run) begin
               imem_req_c = 1'b1;
               ir_we      = mem.imem_ack;
               if (mem.imem_ack) begin
                  state_d = S_DECODE;
               end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_d = S_TRAP;
                  set_bus = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         S_DECODE: begin
            if (dec_cls == C_ILL) begin
               state_d = S_TRAP;
               set_ill = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            alu_src_a = (cls_q == C_AUIPC) || (cls_q == C_JAL) || (cls_q == C_BRANCH);
            alu_src_b = !((cls_q == C_OP) || (cls_q == C_BRANCH));
            if (cls_q == C_BRANCH) begin
               pc_we   = 1'b1;
               pc_sel  = br_taken ? 2'b01 : 2'b00;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if ((cls_q == C_LOAD) || (cls_q == C_STORE)) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEM: begin
            dmem_req_c  = 1'b1;
            dmem_we_c   = (cls_q == C_STORE);
            dmem_size_c = f3_q;
            if (mem.dmem_ack) begin
               // Store completes on the ack itself so the next fetch starts at once
               if (cls_q == C_STORE) begin
                  pc_we   = 1'b1;
                  pc_sel  = 2'b00;
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d = S_TRAP;
               set_bus = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         S_WB: begin
            rf_we = (rd_q != 5'd0);
            case (cls_q)
               C_LOAD:         wb_sel = 2'b01;
               C_JAL, C_JALR:  wb_sel = 2'b10;
               C_LUI:          wb_sel = 2'b11;
               default:        wb_sel = 2'b00;
            endcase
            pc_we = 1'b1;
            case (cls_q)
               C_JAL:   pc_sel = 2'b01;
               C_JALR:  pc_sel = 2'b10;
               default: pc_sel = 2'b00;
            endcase
            retire  = 1'b1;
            state_d = S_FETCH;
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase

      if (state_d != state) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FETCH;
         run       <= 1'b0;
         cnt       <= '0;
         cls_q     <= C_LOAD;
         rd_q      <= 5'd0;
         f3_q      <= 3'd0;
         instret_q <= 32'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         run   <= 1'b1;
         state <= state_d;
         cnt   <= cnt_d;
         if (state == S_DECODE) begin
            cls_q <= dec_cls;
            rd_q  <= rd;
            f3_q  <= funct3;
         end
         if (instret_we) begin
            instret_q <= instret_wdata;
         end else if (retire) begin
            instret_q <= instret_q + 32'd1;
         end
         if (set_ill) begin
            illegal_q <= 1'b1;
         end
         if (set_bus) begin
            bus_err_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model expands each
// instruction into its expected per-cycle outputs, checked every cycle.
module tb_multicycle_ctrl;

   localparam int TMO = 4;

   localparam int K_LOAD = 0, K_STORE = 1, K_OPIMM = 2, K_OP = 3, K_BRANCH = 4;
   localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

   typedef struct packed {
      logic        iack;
      logic        dack;
      logic        imem_req;
      logic        ir_we;
      logic        dmem_req;
      logic        dmem_we;
      logic [2:0]  dmem_size;
      logic        alu_a;
      logic        alu_b;
      logic        rf_we;
      logic [1:0]  wb_sel;
      logic        pc_we;
      logic [1:0]  pc_sel;
      logic        retire;
      logic [31:0] instret;
      logic        illegal;
      logic        bus_err;
   } cyc_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  operation;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic        br_taken;
   logic        instret_we;
   logic [31:0] instret_wdata;
   logic        ir_we, alu_src_a, alu_src_b, rf_we, pc_we, retire, illegal, bus_err;
   logic [1:0]  wb_sel, pc_sel;
   logic [31:0] instret;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(
      .TIMEOUT_CYCLES(TMO),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem(bus.master),
      .operation(operation),
      .funct3(funct3),
      .rd(rd),
      .br_taken(br_taken),
      .instret_we(instret_we),
      .instret_wdata(instret_wdata),
      .ir_we(ir_we),
      .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b),
      .rf_we(rf_we),
      .wb_sel(wb_sel),
      .pc_we(pc_we),
      .pc_sel(pc_sel),
      .retire(retire),
      .instret(instret),
      .illegal(illegal),
      .bus_err(bus_err)
   );

   initial forever #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc_cnt = 0;
   int          abort_at = 0;
   int          last_len = 0;
   bit          aborted = 0;
   logic [31:0] m_instret = 0;
   logic        m_ill = 0;
   logic        m_bus = 0;
   cyc_t        exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic int mclass(input logic [6:0] op);
      case (op)
         7'b0000011: return K_LOAD;
         7'b0100011: return K_STORE;
         7'b0010011: return K_OPIMM;
         7'b0110011: return K_OP;
         7'b1100011: return K_BRANCH;
         7'b1101111: return K_JAL;
         7'b1100111: return K_JALR;
         7'b0110111: return K_LUI;
         7'b0010111: return K_AUIPC;
         default:    return K_ILL;
      endcase
   endfunction

   // One clock cycle: drive acks, queue the expectation, advance past the edge.
   task automatic emit(input cyc_t e);
      if (aborted) return;
      if (abort_at > 0 && cyc_cnt >= abort_at) begin
         aborted = 1;
         return;
      end
      e.instret    = m_instret;
      e.illegal    = m_ill;
      e.bus_err    = m_bus;
      bus.imem_ack = e.iack;
      bus.dmem_ack = e.dack;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (instret_we) begin
         m_instret  = instret_wdata;
         instret_we = 1'b0;
      end else if (e.retire) begin
         m_instret = m_instret + 32'd1;
      end
   endtask

   task automatic trap_tail();
      cyc_t e;
      for (int i = 0; i < 3; i++) begin
         e      = '0;
         e.iack = 1'b1;
         e.dack = 1'b1;
         emit(e);
      end
   endtask

   // iw/dw: non-ack cycles before the fetch/data ack.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rdv,
                            input logic br, input int iw, input int dw);
      cyc_t e;
      int   c;
      int   start;
      c         = mclass(op);
      start     = cyc_cnt;
      operation = op;
      funct3    = f3;
      rd        = rdv;
      br_taken  = br;
      for (int k = 0; k <= iw; k++) begin
         e          = '0;
         e.imem_req = 1'b1;
         if (k == iw) begin
            e.iack  = 1'b1;
            e.ir_we = 1'b1;
         end else if (k + 1 == TMO) begin
            emit(e);
            if (aborted) return;
            m_bus = 1'b1;
            trap_tail();
            last_len = cyc_cnt - start;
            return;
         end
         emit(e);
         if (aborted) return;
      end
      e = '0;
      emit(e);
      if (aborted) return;
      if (c == K_ILL) begin
         m_ill = 1'b1;
         trap_tail();
         last_len = cyc_cnt - start;
         return;
      end
      operation = 7'h7f;
      funct3    = ~f3;
      rd        = ~rdv;
      e         = '0;
      e.alu_a   = (c == K_AUIPC) || (c == K_JAL) || (c == K_BRANCH);
      e.alu_b   = !((c == K_OP) || (c == K_BRANCH));
      if (c == K_BRANCH) begin
         e.pc_we  = 1'b1;
         e.pc_sel = br ? 2'b01 : 2'b00;
         e.retire = 1'b1;
      end
      emit(e);
      if (aborted) return;
      if (c == K_BRANCH) begin
         last_len = cyc_cnt - start;
         return;
      end
      if (c == K_LOAD || c == K_STORE) begin
         for (int k = 0; k <= dw; k++) begin
            e           = '0;
            e.dmem_req  = 1'b1;
            e.dmem_we   = (c == K_STORE);
            e.dmem_size = f3;
            if (k == dw) begin
               e.dack = 1'b1;
               if (c == K_STORE) begin
                  e.pc_we  = 1'b1;
                  e.retire = 1'b1;
               end
            end else if (k + 1 == TMO) begin
               emit(e);
               if (aborted) return;
               m_bus = 1'b1;
               trap_tail();
               last_len = cyc_cnt - start;
               return;
            end
            emit(e);
            if (aborted) return;
         end
         if (c == K_STORE) begin
            last_len = cyc_cnt - start;
            return;
         end
      end
      e        = '0;
      e.rf_we  = (rdv != 5'd0);
      e.wb_sel = (c == K_LOAD) ? 2'b01 :
                 (c == K_JAL || c == K_JALR) ? 2'b10 :
                 (c == K_LUI) ? 2'b11 : 2'b00;
      e.pc_we  = 1'b1;
      e.pc_sel = (c == K_JAL) ? 2'b01 : (c == K_JALR) ? 2'b10 : 2'b00;
      e.retire = 1'b1;
      emit(e);
      last_len = cyc_cnt - start;
   endtask

   task automatic do_reset();
      cyc_t e;
      rst = 1'b1;
      #1;
      chk("rst_imem_req", bus.imem_req, 0);
      chk("rst_dmem_req", bus.dmem_req, 0);
      chk("rst_ir_we", ir_we, 0);
      chk("rst_pc_we", pc_we, 0);
      chk("rst_retire", retire, 0);
      chk("rst_instret", instret, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_bus_err", bus_err, 0);
      exp_q.delete();
      m_instret    = 0;
      m_ill        = 0;
      m_bus        = 0;
      aborted      = 0;
      abort_at     = 0;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      e   = '0;
      emit(e);
   endtask

   always @(negedge clk) begin
      cyc_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("imem_req", bus.imem_req, e.imem_req);
         chk("ir_we", ir_we, e.ir_we);
         chk("dmem_req", bus.dmem_req, e.dmem_req);
         chk("dmem_we", bus.dmem_we, e.dmem_we);
         chk("dmem_size", bus.dmem_size, e.dmem_size);
         chk("alu_src_a", alu_src_a, e.alu_a);
         chk("alu_src_b", alu_src_b, e.alu_b);
         chk("rf_we", rf_we, e.rf_we);
         chk("wb_sel", wb_sel, e.wb_sel);
         chk("pc_we", pc_we, e.pc_we);
         chk("pc_sel", pc_sel, e.pc_sel);
         chk("retire", retire, e.retire);
         chk("instret", instret, e.instret);
         chk("illegal", illegal, e.illegal);
         chk("bus_err", bus_err, e.bus_err);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      operation     = 7'd0;
      funct3        = 3'd0;
      rd            = 5'd0;
      br_taken      = 1'b0;
      instret_we    = 1'b0;
      instret_wdata = 32'd0;
      bus.imem_ack  = 1'b0;
      bus.dmem_ack  = 1'b0;
      do_reset();

      run_instr(7'b0110011, 3'b000, 5'd5, 1'b0, 0, 0);
      chk("op_len", last_len, 4);
      chk("op_instret", instret, 1);
      run_instr(7'b0000011, 3'b010, 5'd9, 1'b0, 0, 3);
      chk("load_len", last_len, 8);
      run_instr(7'b0100011, 3'b001, 5'd0, 1'b0, 0, 3);
      chk("store_len", last_len, 7);
      run_instr(7'b1100011, 3'b000, 5'd4, 1'b1, 0, 0);
      chk("br_taken_len", last_len, 3);
      run_instr(7'b1100011, 3'b001, 5'd4, 1'b0, 0, 0);
      chk("br_not_taken_len", last_len, 3);
      run_instr(7'b1100111, 3'b000, 5'd0, 1'b0, 0, 0);
      run_instr(7'b0010011, 3'b100, 5'd1, 1'b0, 1, 0);
      run_instr(7'b0110111, 3'b000, 5'd2, 1'b0, 0, 0);
      run_instr(7'b0010111, 3'b000, 5'd3, 1'b0, 0, 0);
      run_instr(7'b1101111, 3'b000, 5'd31, 1'b0, 2, 0);
      chk("mix_instret", instret, 10);

      run_instr(7'b0000000, 3'b000, 5'd1, 1'b0, 0, 0);
      chk("illegal_set", illegal, 1);
      chk("illegal_no_bus_err", bus_err, 0);
      do_reset();

      run_instr(7'b0110011, 3'b000, 5'd5, 1'b0, 10, 0);
      chk("timeout_bus_err", bus_err, 1);
      chk("timeout_len", last_len, 7);
      do_reset();

      run_instr(7'b0110011, 3'b000, 5'd5, 1'b0, TMO - 1, 0);
      chk("ack_at_timeout_len", last_len, 7);
      chk("ack_at_timeout_bus_err", bus_err, 0);

      abort_at = cyc_cnt + 4;
      run_instr(7'b0000011, 3'b010, 5'd3, 1'b0, 0, 10);
      abort_at = 0;
      chk("mid_mem_dmem_req", bus.dmem_req, 1);
      chk("mid_mem_instret", instret, 1);
      do_reset();

      instret_we    = 1'b1;
      instret_wdata = 32'hFFFF_FFFF;
      run_instr(7'b0110111, 3'b000, 5'd7, 1'b0, 0, 0);
      chk("instret_wrap", instret, 0);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
